// File: rtl/aes256_key_loader.sv
// Collects a 256-bit AES key as eight 32-bit words and commits it atomically to the
// key expansion input. key_valid is raised once the expansion chain has had time to settle.
module aes256_key_loader #(
    parameter int   SETTLE_CYCLES      = 16,
    parameter logic LOCK_DURING_SETTLE = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [31:0]  wr_data,
    input  logic         wr_valid,
    output logic         wr_ready,
    input  logic         flush,
    output logic [255:0] key_out,
    output logic         key_valid,
    output logic         key_commit,
    output logic [2:0]   word_cnt
);

    typedef enum logic [1:0] {
        EMPTY,
        SETTLING,
        VALID
    } state_t;

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [7:0]     r_settle_cnt;
    // Only words 0..6 are stored; the eighth word goes straight from wr_data into key_out.
    logic [223:0]   r_shadow;
    logic [2:0]     r_word_cnt;
    logic [255:0]   r_key;
    logic           r_commit;
    logic           w_handshake;
    logic           w_commit;
    logic           w_settle_done;

    assign wr_ready      = rst_n && !flush && !(LOCK_DURING_SETTLE && (r_state == SETTLING));
    assign w_handshake   = wr_valid && wr_ready;
    assign w_commit      = w_handshake && (r_word_cnt == 3'd7);
    assign w_settle_done = (r_state == SETTLING) && (r_settle_cnt == 8'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_commit) begin
            w_state_nxt = SETTLING;
        end else if (w_settle_done) begin
            w_state_nxt = VALID;
        end
    end

    // A commit always reloads the counter, even one arriving mid-settle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_settle_cnt <= 8'd0;
        end else if (w_commit) begin
            r_settle_cnt <= SETTLE_LOAD;
        end else if ((r_state == SETTLING) && (r_settle_cnt != 8'd0)) begin
            r_settle_cnt <= r_settle_cnt - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow   <= '0;
            r_word_cnt <= 3'd0;
        end else if (flush) begin
            r_shadow   <= '0;
            r_word_cnt <= 3'd0;
        end else if (w_handshake) begin
            for (int i = 0; i < 7; i++) begin
                if (r_word_cnt == 3'(i)) begin
                    r_shadow[223 - 32*i -: 32] <= wr_data;
                end
            end
            r_word_cnt <= r_word_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key    <= '0;
            r_commit <= 1'b0;
        end else begin
            r_commit <= w_commit;
            if (w_commit) begin
                r_key <= {r_shadow, wr_data};
            end
        end
    end

    assign key_out    = r_key;
    assign key_valid  = (r_state == VALID);
    assign key_commit = r_commit;
    assign word_cnt   = r_word_cnt;

endmodule

// File: doc/aes256_key_loader.md
Name: aes256_key_loader

Overview:
- Upstream feeder for the AES-256 key expansion stage.
- Collects a 256-bit cipher key as eight 32-bit words over a valid/ready write interface, in a shadow register.
- Commits all eight words atomically onto a stable 256-bit key bus that drives the key expansion input.
- Key expansion is a registered chain, so the loader holds the key steady for a settle window. It asserts key_valid only once every round key (Key_0..Key_14) has settled.

Parameters:
SETTLE_CYCLES, 16, rising edges after a commit before key_valid asserts; legal range 1..255. Key_14 settles in 13 edges, so 16 gives margin.
LOCK_DURING_SETTLE, 1, 1 = wr_ready held low while settling; 0 = writes accepted while settling.

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
wr_data  in  32  key word; first word accepted = key bits [255:224], eighth = [31:0]
wr_valid  in  1  wr_data valid
wr_ready  out  1  loader can accept a word; transfer when wr_valid && wr_ready at a rising edge
flush  in  1  synchronous discard of a partially collected key
key_out  out  256  committed key, to key expansion input
key_valid  out  1  key_out committed and all round keys settled
key_commit  out  1  one-cycle pulse: key_out changed this cycle
word_cnt  out  3  words collected in the shadow register (0..7)

Behaviour:
- Reset values (rst_n low, asynchronous):
  - key_out=0, key_valid=0, key_commit=0, word_cnt=0, shadow=0, settle counter=0, state EMPTY.
  - wr_ready reads 0 while rst_n is low.
- Key state machine: EMPTY -> SETTLING on commit; SETTLING -> VALID when the settle counter expires; VALID -> SETTLING on commit. No other transitions except reset.
- wr_ready = rst_n && !flush && !(LOCK_DURING_SETTLE && state==SETTLING).
- Collection:
  - Each accepted word is written into shadow slot word_cnt (slot 0 = bits [255:224]).
  - word_cnt increments by 1 on each accepted word.
  - wr_valid may drop between words with no effect.
  - wr_data is ignored when no handshake occurs.
- Commit, on the edge of the 8th accepted word (word_cnt==7 && handshake):
  - key_out <= {shadow[255:32], wr_data} in the same edge.
  - word_cnt wraps to 0.
  - key_commit=1 for exactly the following cycle.
  - key_valid <= 0.
  - Settle counter loads SETTLE_CYCLES; state <= SETTLING.
- Settling:
  - The counter decrements on every edge.
  - key_valid goes high at the SETTLE_CYCLES-th rising edge after the commit edge; state <= VALID.
  - key_valid stays high until the next commit or reset.
- Latency: first word accepted to key_valid = 7 + SETTLE_CYCLES edges minimum (no gaps), i.e. 23 at default.
- Commit while SETTLING (only possible with LOCK_DURING_SETTLE=0):
  - key_out updates and key_commit pulses again.
  - The counter reloads to SETTLE_CYCLES; key_valid stays 0.
- Commit while VALID: key_valid falls in the cycle after the commit edge, coincident with key_commit.
- Flush:
  - Clears word_cnt and shadow on the next edge.
  - Does not affect key_out, key_valid, key_commit, the settle counter or state.
  - Because wr_ready is low during flush, a simultaneous wr_valid is not accepted and the word is dropped; the source must resend it.
- key_out changes only on commit edges and on reset, never on partial collection.
- Reset mid-collection or mid-settle: everything returns to reset values immediately; there is no partial commit.

Test Plan:
1. Back-to-back load of words 0x00010203, 0x04050607, … 0x1c1d1e1f, no gaps:
   - key_out=0x000102…1e1f after the 8th edge.
   - key_commit high for 1 cycle.
   - key_valid rises exactly 16 edges after the commit edge.
   - With key expansion attached, Key_1=0x101112131415161718191a1b1c1d1e1f.
2. Same key with random wr_valid gaps (1-5 idle cycles):
   - key_out is unchanged until the 8th word.
   - word_cnt steps 0..7 and then wraps to 0.
   - Commit timing is identical relative to the 8th handshake.
3. Load a key and reach VALID, then write 5 words and assert flush for 1 cycle:
   - word_cnt=0; key_out and key_valid are unchanged.
   - Eight new words 0xffffffff commit key_out=all-ones, and key_valid drops.
4. LOCK_DURING_SETTLE=1: wr_ready is 0 for the 16 cycles after commit and 1 once key_valid rises.
   LOCK_DURING_SETTLE=0: a second full key committed 10 edges into settling gives a second key_commit pulse, and key_valid rises 16 edges after the second commit.
5. Reset asserted after 4 words, and separately at settle count 8:
   - All outputs are 0 asynchronously.
   - After release, a fresh 8-word load behaves as in scenario 1.
6. flush and wr_valid asserted in the same cycle at word_cnt=6: no handshake, and word_cnt is 0 on the next cycle.
